// File: rtl/tacky_fetch.sv
// tacky_fetch: prefetches 16-bit instruction words into a small FIFO and
// unpacks each word into one long or two short instructions for execute.
//
// Ports:
//   clk, reset          clock; asynchronous active-high reset
//   halt                stop issuing memory reads (queued work still drains)
//   redirect            branch taken: flush queue, squash in-flight read,
//   redirect_pc         and refetch from this word address
//   mem_rd, mem_addr    read strobe and word address
//   mem_data            read data, valid the cycle after mem_rd
//   out_valid/out_ready handshake to the execute stage
//   out_inst            long: full word; short: {byte, 8'h00}
//   out_long            out_inst is a long instruction
//   out_pc              word address the instruction came from
//   out_slot            0 = high byte / long, 1 = low byte
//   align_err           one-cycle pulse when a padding byte is discarded
module tacky_fetch #(
    parameter int         DEPTH   = 2,
    parameter logic [4:0] LONGMIN = 5'b10001
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        halt,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        mem_rd,
    output logic [15:0] mem_addr,
    input  logic [15:0] mem_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_inst,
    output logic        out_long,
    output logic [15:0] out_pc,
    output logic        out_slot,
    output logic        align_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 2;
    localparam logic [1:0] S_RUN    = 2'd0;
    localparam logic [1:0] S_HALTED = 2'd1;
    localparam logic [1:0] S_FLUSH  = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [15:0]   fetch_pc_q, fetch_pc_d;
    logic          pend_q, pend_d;
    logic [15:0]   pend_addr_q, pend_addr_d;
    logic [15:0]   word_q [DEPTH];
    logic [15:0]   word_d [DEPTH];
    logic [15:0]   addr_q [DEPTH];
    logic [15:0]   addr_d [DEPTH];
    logic [AW-1:0] head_q, head_d, tail_q, tail_d;
    logic [AW:0]   count_q, count_d;
    logic          sp_q, sp_d;

    logic [15:0]   head_w;
    logic          nonempty, hi_long, lo_long, pad, fire, pop, wr, credit;
    logic [CW-1:0] occ;

    assign head_w   = word_q[head_q];
    assign nonempty = count_q != '0;
    assign hi_long  = head_w[15:11] >= LONGMIN;
    assign lo_long  = head_w[7:3] >= LONGMIN;
    // A long opcode in the low byte can never start an instruction, so the
    // byte is padding and the word is dropped without a handshake.
    assign pad       = nonempty && sp_q && lo_long;
    assign out_valid = nonempty && !pad;
    assign out_long  = out_valid && !sp_q && hi_long;
    assign out_inst  = !out_valid ? 16'h0000 :
                       out_long   ? head_w :
                       sp_q       ? {head_w[7:0], 8'h00} : {head_w[15:8], 8'h00};
    assign out_pc    = out_valid ? addr_q[head_q] : 16'h0000;
    assign out_slot  = out_valid && sp_q;
    assign align_err = pad;

    assign fire = out_valid && out_ready;
    assign pop  = pad || (fire && (out_long || sp_q));
    // Returning data is dropped when a redirect lands in its arrival cycle.
    assign wr   = pend_q && !redirect;

    // Credits count the word leaving this cycle so back-to-back longs can
    // keep one read in flight while the head is consumed.
    assign occ    = CW'(count_q) + CW'(pend_q) - CW'(pop);
    assign credit = occ < CW'(DEPTH);

    assign mem_rd   = !reset && state_q == S_RUN && !halt && !redirect && credit;
    assign mem_addr = fetch_pc_q;

    always_comb begin
        state_d     = redirect ? S_FLUSH : (halt ? S_HALTED : S_RUN);
        fetch_pc_d  = redirect ? redirect_pc : fetch_pc_q + {15'd0, mem_rd};
        pend_d      = mem_rd;
        pend_addr_d = mem_rd ? fetch_pc_q : pend_addr_q;
        word_d      = word_q;
        addr_d      = addr_q;
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        sp_d        = sp_q;
        if (redirect) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            sp_d    = 1'b0;
        end else begin
            if (wr) begin
                word_d[tail_q] = mem_data;
                addr_d[tail_q] = pend_addr_q;
                tail_d         = tail_q + AW'(1);
            end
            head_d  = head_q + AW'(pop);
            count_d = count_q + (AW+1)'(wr) - (AW+1)'(pop);
            sp_d    = pop ? 1'b0 : (fire ? 1'b1 : sp_q);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_RUN;
            fetch_pc_q  <= '0;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            sp_q        <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                word_q[i] <= '0;
                addr_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            sp_q        <= sp_d;
            word_q      <= word_d;
            addr_q      <= addr_d;
        end
    end
endmodule

// File: tb/tb_tacky_fetch.sv
// tb_tacky_fetch: directed and reference-model checks for tacky_fetch.
module tb_tacky_fetch;
    localparam int         DEPTH   = 2;
    localparam logic [4:0] LONGMIN = 5'b10001;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        halt = 1'b0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic [15:0] mem_data = 16'h0000;
    logic        out_ready = 1'b0;
    logic        mem_rd, out_valid, out_long, out_slot, align_err;
    logic [15:0] mem_addr, out_inst, out_pc;

    int n_chk = 0;
    int n_fail = 0;

    tacky_fetch #(.DEPTH(DEPTH), .LONGMIN(LONGMIN)) dut (
        .clk(clk), .reset(reset), .halt(halt), .redirect(redirect),
        .redirect_pc(redirect_pc), .mem_rd(mem_rd), .mem_addr(mem_addr),
        .mem_data(mem_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_inst(out_inst), .out_long(out_long), .out_pc(out_pc),
        .out_slot(out_slot), .align_err(align_err)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] memf(input logic [15:0] a);
        case (a)
            16'h0000: return 16'h4A13;
            16'h0001: return 16'hA5C3;
            16'h0002: return 16'h0890;
            16'h0003: return 16'hC1C2;
            16'h0100: return 16'h2244;
            16'hFFFF: return 16'h3311;
            default:  return {a[7:0] ^ 8'h5A, a[7:0]};
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
        end
    endtask

    task automatic check_reset_outs(input string tag);
        chk({tag, "_mem_rd"}, mem_rd, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_inst"}, out_inst, 0);
        chk({tag, "_out_long"}, out_long, 0);
        chk({tag, "_out_pc"}, out_pc, 0);
        chk({tag, "_out_slot"}, out_slot, 0);
        chk({tag, "_align_err"}, align_err, 0);
    endtask

    task automatic wait_rd(output logic [15:0] a);
        int i;
        i = 0;
        do begin
            @(negedge clk);
            i++;
        end while (!mem_rd && i < 20);
        chk("rd_seen", mem_rd, 1);
        a = mem_addr;
    endtask

    // Memory: answers each read with its word during the following cycle.
    initial begin
        logic        r;
        logic [15:0] a;
        forever begin
            @(negedge clk);
            r = mem_rd;
            a = mem_addr;
            @(posedge clk);
            #1 mem_data = r ? memf(a) : 16'hDEAD;
        end
    end

    // Reference model: the instruction stream is the memory image walked
    // word by word from the last redirect target, split by opcode class.
    logic [15:0] m_pc, f_pc, w, e_inst;
    logic        m_sp, padm, e_long, halt_p, redir_p;
    int          outst;
    int          n_align = 0;
    int          align_pos = -1;
    logic [15:0] log_inst [$];
    logic [15:0] log_pc [$];
    logic        log_slot [$];
    logic        log_long [$];

    always @(negedge clk) begin
        if (reset) begin
            m_pc = 0; m_sp = 0; f_pc = 0; outst = 0; halt_p = 0; redir_p = 0;
        end else begin
            w      = memf(m_pc);
            padm   = m_sp && (w[7:3] >= LONGMIN);
            e_long = !m_sp && (w[15:11] >= LONGMIN);
            e_inst = e_long ? w : (m_sp ? {w[7:0], 8'h00} : {w[15:8], 8'h00});
            if (out_valid) begin
                chk("valid_on_padding", padm, 0);
                chk("out_inst", out_inst, e_inst);
                chk("out_long", out_long, e_long);
                chk("out_pc", out_pc, m_pc);
                chk("out_slot", out_slot, m_sp);
                chk("align_with_valid", align_err, 0);
                if (out_ready) begin
                    log_inst.push_back(out_inst);
                    log_pc.push_back(out_pc);
                    log_slot.push_back(out_slot);
                    log_long.push_back(out_long);
                    if (e_long || m_sp) begin
                        m_pc++; m_sp = 0; outst--;
                    end else m_sp = 1;
                end
            end else if (align_err) begin
                chk("align_expected", padm, 1);
                n_align++;
                align_pos = log_inst.size();
                m_pc++; m_sp = 0; outst--;
            end
            if (mem_rd) begin
                chk("issue_allowed", halt || halt_p || redir_p, 0);
                chk("mem_addr", mem_addr, f_pc);
                f_pc++;
                outst++;
                chk("credit", outst <= DEPTH, 1);
            end
            if (redirect) begin
                m_pc = redirect_pc; m_sp = 0; f_pc = redirect_pc; outst = 0;
            end
            halt_p  = halt;
            redir_p = redirect;
        end
    end

    initial begin
        logic [15:0] a;
        logic [15:0] held;
        int i;
        out_ready = 1;
        repeat (2) @(posedge clk);
        #1 check_reset_outs("init");
        reset = 0;
        @(negedge clk);
        chk("first_rd", mem_rd, 1);
        chk("first_addr", mem_addr, 16'h0000);
        chk("c0_valid", out_valid, 0);
        @(negedge clk);
        chk("c1_valid", out_valid, 0);
        @(negedge clk);
        chk("c2_valid", out_valid, 1);
        chk("c2_inst", out_inst, 16'h4A00);

        i = 0;
        while (log_inst.size() < 5 && i < 40) begin
            @(negedge clk);
            i++;
        end
        chk("p1_count", log_inst.size() >= 5, 1);
        chk("p1_i0", {log_inst[0], log_pc[0], 7'd0, log_slot[0], 7'd0, log_long[0]}, {16'h4A00, 16'h0000, 16'h0000});
        chk("p1_i1", {log_inst[1], log_pc[1], 7'd0, log_slot[1], 7'd0, log_long[1]}, {16'h1300, 16'h0000, 16'h0100});
        chk("p1_i2", {log_inst[2], log_pc[2], 7'd0, log_slot[2], 7'd0, log_long[2]}, {16'hA5C3, 16'h0001, 16'h0001});
        chk("p1_i3", {log_inst[3], log_pc[3], 7'd0, log_slot[3], 7'd0, log_long[3]}, {16'h0800, 16'h0002, 16'h0000});
        chk("p1_i4", {log_inst[4], log_pc[4], 7'd0, log_slot[4], 7'd0, log_long[4]}, {16'hC1C2, 16'h0003, 16'h0001});
        chk("p1_align_n", n_align, 1);
        chk("p1_align_pos", align_pos, 4);

        @(posedge clk);
        #1 out_ready = 0;
        held = 16'h0000;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (k == 3) held = out_inst;
            if (k >= 4) begin
                chk("stall_no_rd", mem_rd, 0);
                chk("stall_stable", out_inst, held);
            end
        end
        chk("stall_valid", out_valid, 1);
        @(posedge clk);
        #1 out_ready = 1;

        @(posedge clk);
        #1 halt = 1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("halt_no_rd", mem_rd, 0);
        end
        @(posedge clk);
        #1 halt = 0;
        @(negedge clk);
        chk("halted_exit_no_rd", mem_rd, 0);

        wait_rd(a);
        @(posedge clk);
        #1 redirect = 1;
        redirect_pc = 16'h0100;
        @(posedge clk);
        #1 redirect = 0;
        @(negedge clk);
        chk("flush_rd", mem_rd, 0);
        chk("flush_valid", out_valid, 0);
        @(negedge clk);
        chk("redir_rd", mem_rd, 1);
        chk("redir_addr", mem_addr, 16'h0100);
        chk("redir_valid_early", out_valid, 0);
        @(negedge clk);
        chk("redir_valid_data", out_valid, 0);
        @(negedge clk);
        chk("redir_valid", out_valid, 1);
        chk("redir_pc", out_pc, 16'h0100);
        chk("redir_slot", out_slot, 0);
        chk("redir_inst", out_inst, 16'h2200);

        @(posedge clk);
        #1 redirect = 1;
        redirect_pc = 16'hFFFF;
        @(posedge clk);
        #1 redirect = 0;
        wait_rd(a);
        chk("wrap_first", a, 16'hFFFF);
        wait_rd(a);
        chk("wrap_next", a, 16'h0000);

        repeat (5) @(posedge clk);
        #3 reset = 1;
        #1 check_reset_outs("mid");
        repeat (2) @(posedge clk);
        #1 reset = 0;
        @(negedge clk);
        chk("rst_resume_rd", mem_rd, 1);
        chk("rst_resume_addr", mem_addr, 16'h0000);

        for (int k = 0; k < 120; k++) begin
            @(posedge clk);
            #1 out_ready = 1'($urandom_range(0, 1));
            halt = ($urandom_range(0, 7) == 0);
            redirect = ($urandom_range(0, 11) == 0);
            redirect_pc = 16'($urandom_range(0, 65535));
        end
        @(posedge clk);
        #1 halt = 0;
        redirect = 0;
        out_ready = 1;
        repeat (10) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
